// File: rtl/instr_sequencer_if.sv
// Instruction-memory port bundle for instr_sequencer.
// master: sequencer side (drives en/addr); slave: ROM side (drives rdata).
// Signals: imem_en, imem_addr (byte address), imem_rdata (valid one cycle after en).
interface instr_sequencer_if #(
    parameter int ADDR_W = 14
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/PC controller for the single-cycle core: FETCH then EXEC per instruction.
// Ports: clck, rst_n (sync, active low), run, resume, halt_req, imem (master),
//   instr_out/instr_valid, branch_taken/branch_target, pc_out, halted,
//   err_misalign (sticky), retired_cnt.
// Macro SINGLE_STEP_EN adds input step: one instruction per pulse from IDLE.
module instr_sequencer #(
    parameter int                ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clck,
    input  logic              rst_n,
    input  logic              run,
    input  logic              resume,
    input  logic              halt_req,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    instr_sequencer_if.master imem,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              err_misalign,
    output logic [31:0]       retired_cnt
);

    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;
    logic [31:0]       ret_q;
    logic              retire;
    // Set while the instruction in flight was launched by a step pulse,
    // so EXEC falls back to IDLE even if run rises meanwhile.
    logic              step_q, step_d;

    always_ff @(posedge clck) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            ret_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            ret_q   <= ret_q + 32'(retire);
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        err_d        = err_q;
        step_d       = step_q;
        retire       = 1'b0;
        imem.imem_en = 1'b0;
        instr_valid  = 1'b0;
        instr_out    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end
`ifdef SINGLE_STEP_EN
                else if (step) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
`endif
            end
            S_FETCH: begin
                imem.imem_en = 1'b1;
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                instr_out   = imem.imem_rdata;
                // A misaligned redirect faults: PC kept, nothing retired.
                if (branch_taken && branch_target[1:0] != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    retire = 1'b1;
                    pc_d   = branch_taken ? branch_target
                                          : pc_q + ADDR_W'(4);
                    if (imem.imem_rdata == ECALL || halt_req)
                        state_d = S_HALT;
                    else if (run && !step_q)
                        state_d = S_FETCH;
                    else
                        state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if (resume && !err_q) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem.imem_addr = pc_q;
    assign pc_out         = pc_q;
    assign halted         = (state_q == S_HALT);
    assign err_misalign   = err_q;
    assign retired_cnt    = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: ROM model, core branch/halt model,
// and a scoreboard of expected (pc, instr) pairs popped on each instr_valid.
module tb_instr_sequencer;

    localparam int          AW     = 14;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] ECALLW = 32'h0000_0073;
    localparam logic [31:0] BEQ    = 32'h0000_0063;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          run   = 1'b0;
    logic          resume = 1'b0;
    logic          halt_req;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [31:0]   instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc_out;
    logic          halted;
    logic          err_misalign;
    logic [31:0]   retired_cnt;
`ifdef SINGLE_STEP_EN
    logic          step = 1'b0;
`endif

    logic [AW-1:0] br_tgt  = '0;
    logic          hreq_en = 1'b0;
    logic [AW-1:0] hreq_pc = '0;

    instr_sequencer_if #(.ADDR_W(AW)) imem ();

    instr_sequencer #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .clck          (clk),
        .rst_n         (rst_n),
        .run           (run),
        .resume        (resume),
        .halt_req      (halt_req),
`ifdef SINGLE_STEP_EN
        .step          (step),
`endif
        .imem          (imem.master),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .halted        (halted),
        .err_misalign  (err_misalign),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [4096];

    always @(posedge clk)
        if (imem.imem_en)
            imem.imem_rdata <= rom[imem.imem_addr[AW-1:2]];

    // Core model: any B-type opcode branches to br_tgt.
    always_comb begin
        branch_taken  = instr_valid && (instr_out[6:0] == 7'h63);
        branch_target = br_tgt;
        halt_req      = hreq_en && instr_valid && (pc_out == hreq_pc);
    end

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   ins;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic prev_v = 1'b0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_pc(logic [AW-1:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = rom[pc[AW-1:2]];
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && instr_valid) begin
            check("valid_b2b", 64'(prev_v), 64'(0));
            if (sbq.size() == 0) begin
                check("extra_instr", 64'(sbq.size()), 64'(1));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_pc", 64'(pc_out), 64'(e.pc));
                check("sb_instr", 64'(instr_out), 64'(e.ins));
            end
        end
        prev_v <= rst_n && instr_valid;
    end

    task automatic rom_fill();
        for (int i = 0; i < 4096; i++) rom[i] = ADDI;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        run     = 1'b0;
        resume  = 1'b0;
        hreq_en = 1'b0;
        sbq.delete();
        rom_fill();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(string tag, int budget);
        int k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(halted), 64'(1));
    endtask

    task automatic wait_q(string tag, int budget);
        int k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(sbq.size()), 64'(0));
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
    endtask

    initial begin
        rom_fill();
        repeat (3) @(negedge clk);
        check("rst_en", 64'(imem.imem_en), 64'(0));
        check("rst_addr", 64'(imem.imem_addr), 64'(0));
        check("rst_valid", 64'(instr_valid), 64'(0));
        check("rst_instr", 64'(instr_out), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_err", 64'(err_misalign), 64'(0));
        check("rst_ret", 64'(retired_cnt), 64'(0));
        check("rst_pc", 64'(pc_out), 64'(0));

        // Sequential run of four ADDIs; run dropped during the 4th FETCH.
        rst_n = 1'b1;
        rom[0] = 32'h0010_0093;
        rom[1] = 32'h0020_0113;
        rom[2] = 32'h0030_0193;
        rom[3] = 32'h0040_0213;
        @(negedge clk);
        check("idle_en", 64'(imem.imem_en), 64'(0));
        expect_pc('h0);
        expect_pc('h4);
        expect_pc('h8);
        expect_pc('hC);
        run = 1'b1;
        repeat (7) @(posedge clk);
        #1 run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("seq_ret", 64'(retired_cnt), 64'(4));
        check("seq_pc", 64'(pc_out), 64'('h10));
        check("seq_sb", 64'(sbq.size()), 64'(0));
        @(negedge clk);
        check("seq_idle_en", 64'(imem.imem_en), 64'(0));
        check("seq_idle_ret", 64'(retired_cnt), 64'(4));

        // Branch at 8 to 0x40, then ECALL at 0x44.
        do_reset();
        rom[2]        = BEQ;
        rom['h44 >> 2] = ECALLW;
        br_tgt = 'h40;
        expect_pc('h0);
        expect_pc('h4);
        expect_pc('h8);
        expect_pc('h40);
        expect_pc('h44);
        run = 1'b1;
        wait_halt("br_halt", 40);
        run = 1'b0;
        check("br_ret", 64'(retired_cnt), 64'(5));
        check("br_pc", 64'(pc_out), 64'('h48));
        check("br_err", 64'(err_misalign), 64'(0));
        check("br_sb", 64'(sbq.size()), 64'(0));

        // Misaligned redirect: fault, sticky, resume ignored.
        do_reset();
        rom[2] = BEQ;
        br_tgt = 'h42;
        expect_pc('h0);
        expect_pc('h4);
        expect_pc('h8);
        run = 1'b1;
        wait_halt("mis_halt", 30);
        check("mis_err", 64'(err_misalign), 64'(1));
        check("mis_pc", 64'(pc_out), 64'('h8));
        check("mis_ret", 64'(retired_cnt), 64'(2));
        pulse_resume();
        repeat (4) @(negedge clk);
        check("mis_stay", 64'(halted), 64'(1));
        check("mis_en", 64'(imem.imem_en), 64'(0));
        check("mis_ret2", 64'(retired_cnt), 64'(2));
        check("mis_pc2", 64'(pc_out), 64'('h8));
        run = 1'b0;

        // ECALL at 0x10, resume continues at 0x14; resume in IDLE ignored.
        do_reset();
        check("rst_err_clr", 64'(err_misalign), 64'(0));
        pulse_resume();
        repeat (3) @(negedge clk);
        check("idle_resume", 64'(retired_cnt), 64'(0));
        check("idle_resume_h", 64'(halted), 64'(0));
        rom[4] = ECALLW;
        rom[6] = ECALLW;
        expect_pc('h0);
        expect_pc('h4);
        expect_pc('h8);
        expect_pc('hC);
        expect_pc('h10);
        run = 1'b1;
        wait_halt("ec_halt", 40);
        check("ec_pc", 64'(pc_out), 64'('h14));
        check("ec_ret", 64'(retired_cnt), 64'(5));
        expect_pc('h14);
        expect_pc('h18);
        pulse_resume();
        wait_q("ec_q2", 20);
        wait_halt("ec_halt2", 10);
        check("ec_pc2", 64'(pc_out), 64'('h1C));
        check("ec_ret2", 64'(retired_cnt), 64'(7));
        run = 1'b0;

        // halt_req with branch to 0x3FFC, then PC+4 wraps to 0.
        do_reset();
        rom[0]  = BEQ;
        br_tgt  = 'h3FFC;
        hreq_pc = '0;
        hreq_en = 1'b1;
        expect_pc('h0);
        run = 1'b1;
        wait_halt("wr_halt", 20);
        check("wr_pc", 64'(pc_out), 64'('h3FFC));
        check("wr_ret", 64'(retired_cnt), 64'(1));
        hreq_en = 1'b0;
        rom[0]  = ECALLW;
        expect_pc('h3FFC);
        expect_pc('h0);
        pulse_resume();
        wait_q("wr_q", 20);
        wait_halt("wr_halt2", 10);
        check("wr_pc2", 64'(pc_out), 64'('h4));
        check("wr_ret2", 64'(retired_cnt), 64'(3));
        run = 1'b0;

`ifdef SINGLE_STEP_EN
        // Three step pulses with run low: exactly three instructions.
        do_reset();
        expect_pc('h0);
        expect_pc('h4);
        expect_pc('h8);
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("st_ret", 64'(retired_cnt), 64'(3));
        check("st_sb", 64'(sbq.size()), 64'(0));
        check("st_pc", 64'(pc_out), 64'('hC));
        check("st_en", 64'(imem.imem_en), 64'(0));
        check("st_halted", 64'(halted), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
